// File: rtl/wb_regfile_pkg.sv
// Shared widths, register-file constants and the MEM/WB latch layout for the
// write-back stage.
package wb_regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int CSR_ADDR_W = 12;
    localparam int NREGS      = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG      = '0;
    localparam logic              WRITE_ENABLE  = 1'b1;
    localparam logic              WRITE_DISABLE = 1'b0;

    // Contents of the MEM/WB pipeline latch.
    typedef struct packed {
        logic [ADDR_W-1:0]     rd_addr;
        logic                  wreg;
        logic [DATA_W-1:0]     wdata;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic                  csr_wreg;
        logic [DATA_W-1:0]     csr_wdata;
    } wb_latch_t;

    // True when a forwarding source is valid and targets the requested register.
    function automatic logic src_hit(input logic              valid,
                                     input logic [ADDR_W-1:0] src_addr,
                                     input logic [ADDR_W-1:0] req_addr);
        return valid && (src_addr == req_addr);
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Signal bundle between the MEM stage / ID stage / CSR unit and the
// write-back register file.
//
// Transfer semantics: there is no backpressure. A GPR or CSR write is
// offered whenever its write-enable (wreg_i, csr_wreg_i, mem_back_wreg_i,
// wb_wreg_o, csr_wreg_o) is high on a rising clock edge; address and data are
// only meaningful while that enable is high. stall_i/flush_i act on the
// MEM/WB latch as a whole, and read data is a pure function of the read
// addresses and current state.
interface wb_regfile_if;
    import wb_regfile_pkg::*;

    logic                  stall_i;
    logic                  flush_i;
    logic [ADDR_W-1:0]     rd_addr_i;
    logic                  wreg_i;
    logic [DATA_W-1:0]     wdata_i;
    logic [CSR_ADDR_W-1:0] csr_waddr_i;
    logic                  csr_wreg_i;
    logic [DATA_W-1:0]     csr_wdata_i;
    logic [ADDR_W-1:0]     mem_back_rd_addr_i;
    logic                  mem_back_wreg_i;
    logic [DATA_W-1:0]     mem_back_wdata_i;
    logic [ADDR_W-1:0]     raddr1_i;
    logic [ADDR_W-1:0]     raddr2_i;
    logic [DATA_W-1:0]     rdata1_o;
    logic [DATA_W-1:0]     rdata2_o;
    logic [ADDR_W-1:0]     wb_rd_addr_o;
    logic                  wb_wreg_o;
    logic [DATA_W-1:0]     wb_wdata_o;
    logic [CSR_ADDR_W-1:0] csr_waddr_o;
    logic                  csr_wreg_o;
    logic [DATA_W-1:0]     csr_wdata_o;

    // Pipeline / ID-stage side that drives the block.
    modport master (
        output stall_i, flush_i,
        output rd_addr_i, wreg_i, wdata_i,
        output csr_waddr_i, csr_wreg_i, csr_wdata_i,
        output mem_back_rd_addr_i, mem_back_wreg_i, mem_back_wdata_i,
        output raddr1_i, raddr2_i,
        input  rdata1_o, rdata2_o,
        input  wb_rd_addr_o, wb_wreg_o, wb_wdata_o,
        input  csr_waddr_o, csr_wreg_o, csr_wdata_o
    );

    // The write-back register file itself.
    modport slave (
        input  stall_i, flush_i,
        input  rd_addr_i, wreg_i, wdata_i,
        input  csr_waddr_i, csr_wreg_i, csr_wdata_i,
        input  mem_back_rd_addr_i, mem_back_wreg_i, mem_back_wdata_i,
        input  raddr1_i, raddr2_i,
        output rdata1_o, rdata2_o,
        output wb_rd_addr_o, wb_wreg_o, wb_wdata_o,
        output csr_waddr_o, csr_wreg_o, csr_wdata_o
    );

endinterface

// File: rtl/wb_regfile_gpr_array.sv
// gpr_array: NREGS x DATA_W integer register storage with one synchronous
// write port, two asynchronous read ports and an asynchronous clear.
// x0 is never written and always reads as zero.
module wb_regfile_gpr_array
    import wb_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // Storage: clear everything on reset, otherwise accept one write per edge (x0 discarded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != ZERO_REG)) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous reads, with x0 forced to zero independent of storage contents.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != ZERO_REG) rdata1 = regs[raddr1];
        if (raddr2 != ZERO_REG) rdata2 = regs[raddr2];
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back end of the MEM stage: MEM/WB pipeline latch, the GPR file, the
// registered CSR write towards the CSR unit, and the two ID-stage read ports
// with forwarding priority MEM result > WB latch > storage.
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);

    wb_latch_t         latch_q;
    wb_latch_t         latch_in;
    logic [DATA_W-1:0] store_rdata1;
    logic [DATA_W-1:0] store_rdata2;

    // Gather the MEM-stage fields into the latch layout.
    always_comb begin
        latch_in           = '0;
        latch_in.rd_addr   = bus.rd_addr_i;
        latch_in.wreg      = bus.wreg_i;
        latch_in.wdata     = bus.wdata_i;
        latch_in.csr_waddr = bus.csr_waddr_i;
        latch_in.csr_wreg  = bus.csr_wreg_i;
        latch_in.csr_wdata = bus.csr_wdata_i;
    end

    // MEM/WB latch: flush clears it (even when stalled), stall holds it, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_q <= '0;
        end else if (bus.flush_i) begin
            latch_q <= '0;
        end else if (!bus.stall_i) begin
            latch_q <= latch_in;
        end
    end

    // The latched write drives storage directly; while stalled the same write repeats harmlessly.
    wb_regfile_gpr_array u_gpr_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (latch_q.wreg),
        .waddr  (latch_q.rd_addr),
        .wdata  (latch_q.wdata),
        .raddr1 (bus.raddr1_i),
        .raddr2 (bus.raddr2_i),
        .rdata1 (store_rdata1),
        .rdata2 (store_rdata2)
    );

    // Expose the latch to the GPR write path observers and the CSR unit.
    always_comb begin
        bus.wb_rd_addr_o = latch_q.rd_addr;
        bus.wb_wreg_o    = latch_q.wreg;
        bus.wb_wdata_o   = latch_q.wdata;
        bus.csr_waddr_o  = latch_q.csr_waddr;
        bus.csr_wreg_o   = latch_q.csr_wreg;
        bus.csr_wdata_o  = latch_q.csr_wdata;
    end

    // Read port 1 bypass: x0 is always zero, then MEM result, then WB latch, then storage.
    always_comb begin
        bus.rdata1_o = store_rdata1;
        if (bus.raddr1_i == ZERO_REG) begin
            bus.rdata1_o = '0;
        end else if (src_hit(bus.mem_back_wreg_i, bus.mem_back_rd_addr_i, bus.raddr1_i)) begin
            bus.rdata1_o = bus.mem_back_wdata_i;
        end else if (src_hit(latch_q.wreg, latch_q.rd_addr, bus.raddr1_i)) begin
            bus.rdata1_o = latch_q.wdata;
        end
    end

    // Read port 2 bypass: same priority as port 1, fully independent of it.
    always_comb begin
        bus.rdata2_o = store_rdata2;
        if (bus.raddr2_i == ZERO_REG) begin
            bus.rdata2_o = '0;
        end else if (src_hit(bus.mem_back_wreg_i, bus.mem_back_rd_addr_i, bus.raddr2_i)) begin
            bus.rdata2_o = bus.mem_back_wdata_i;
        end else if (src_hit(latch_q.wreg, latch_q.rd_addr, bus.raddr2_i)) begin
            bus.rdata2_o = latch_q.wdata;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios followed by randomized traffic,
// all compared against a register-level reference model of the stage.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic clk;
    logic rst_n;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0]     m_regs [NREGS];
    logic [ADDR_W-1:0]     m_rd;
    logic                  m_wreg;
    logic [DATA_W-1:0]     m_wdata;
    logic [CSR_ADDR_W-1:0] m_caddr;
    logic                  m_cwreg;
    logic [DATA_W-1:0]     m_cdata;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_rd = '0; m_wreg = 1'b0; m_wdata = '0;
        m_caddr = '0; m_cwreg = 1'b0; m_cdata = '0;
    endtask

    // What the ID stage should see for a register, given the forwarding rules.
    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (bus.mem_back_wreg_i && bus.mem_back_rd_addr_i == a) return bus.mem_back_wdata_i;
        if (m_wreg && m_rd == a) return m_wdata;
        return m_regs[a];
    endfunction

    // Compare every output against the model for the current inputs.
    task automatic check_outputs(input string tag);
        check({tag, "_rdata1"},  bus.rdata1_o,            exp_read(bus.raddr1_i));
        check({tag, "_rdata2"},  bus.rdata2_o,            exp_read(bus.raddr2_i));
        check({tag, "_wb_rd"},   32'(bus.wb_rd_addr_o),   32'(m_rd));
        check({tag, "_wb_wreg"}, 32'(bus.wb_wreg_o),      32'(m_wreg));
        check({tag, "_wb_data"}, bus.wb_wdata_o,          m_wdata);
        check({tag, "_csr_a"},   32'(bus.csr_waddr_o),    32'(m_caddr));
        check({tag, "_csr_we"},  32'(bus.csr_wreg_o),     32'(m_cwreg));
        check({tag, "_csr_d"},   bus.csr_wdata_o,         m_cdata);
    endtask

    // Advance one clock: the model commits the old latch to storage, then updates the latch.
    task automatic tick();
        if (m_wreg && m_rd != 0) m_regs[m_rd] = m_wdata;
        if (bus.flush_i) begin
            m_rd = '0; m_wreg = 1'b0; m_wdata = '0;
            m_caddr = '0; m_cwreg = 1'b0; m_cdata = '0;
        end else if (!bus.stall_i) begin
            m_rd = bus.rd_addr_i; m_wreg = bus.wreg_i; m_wdata = bus.wdata_i;
            m_caddr = bus.csr_waddr_i; m_cwreg = bus.csr_wreg_i; m_cdata = bus.csr_wdata_i;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.stall_i = 0; bus.flush_i = 0;
        bus.rd_addr_i = '0; bus.wreg_i = 0; bus.wdata_i = '0;
        bus.csr_waddr_i = '0; bus.csr_wreg_i = 0; bus.csr_wdata_i = '0;
        bus.mem_back_rd_addr_i = '0; bus.mem_back_wreg_i = 0; bus.mem_back_wdata_i = '0;
    endtask

    // Present a GPR write on MEM, mirrored on the MEM forwarding path.
    task automatic drive_mem(input logic [ADDR_W-1:0] rd, input logic we, input logic [DATA_W-1:0] d);
        bus.rd_addr_i = rd; bus.wreg_i = we; bus.wdata_i = d;
        bus.mem_back_rd_addr_i = rd; bus.mem_back_wreg_i = we; bus.mem_back_wdata_i = d;
    endtask

    task automatic drive_rand();
        bus.stall_i = ($urandom_range(0, 7) == 0);
        bus.flush_i = ($urandom_range(0, 15) == 0);
        bus.rd_addr_i = ADDR_W'($urandom_range(0, 31));
        bus.wreg_i = ($urandom_range(0, 3) != 0);
        bus.wdata_i = $urandom;
        bus.csr_waddr_i = CSR_ADDR_W'($urandom);
        bus.csr_wreg_i = $urandom_range(0, 1) == 1;
        bus.csr_wdata_i = $urandom;
        bus.mem_back_rd_addr_i = ADDR_W'($urandom_range(0, 31));
        bus.mem_back_wreg_i = $urandom_range(0, 1) == 1;
        bus.mem_back_wdata_i = $urandom;
        bus.raddr1_i = ADDR_W'($urandom_range(0, 31));
        bus.raddr2_i = ($urandom_range(0, 3) == 0) ? bus.raddr1_i : ADDR_W'($urandom_range(0, 31));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_fail = 0;
        drive_idle();
        bus.raddr1_i = '0;
        bus.raddr2_i = '0;
        model_reset();
        rst_n = 1'b0;
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1. Storage reads zero after reset; a write is visible at N, N+1, N+2.
        for (int i = 1; i < NREGS; i++) begin
            bus.raddr1_i = ADDR_W'(i);
            bus.raddr2_i = ADDR_W'(NREGS - i);
            #1;
            check("t1_zero1", bus.rdata1_o, 32'h0);
            check("t1_zero2", bus.rdata2_o, 32'h0);
        end
        bus.raddr1_i = 5'd5;
        bus.raddr2_i = 5'd5;
        drive_mem(5'd5, 1'b1, 32'hDEADBEEF);
        #1;
        check("t1_n", bus.rdata1_o, 32'hDEADBEEF);
        check_outputs("t1_n");
        tick();
        drive_mem(5'd0, 1'b0, 32'h0);
        #1;
        check("t1_n1", bus.rdata1_o, 32'hDEADBEEF);
        check("t1_n1_wb", 32'(bus.wb_wreg_o), 32'h1);
        tick();
        check("t1_n2", bus.rdata1_o, 32'hDEADBEEF);
        check("t1_n2_wbidle", 32'(bus.wb_wreg_o), 32'h0);
        tick();
        check("t1_n3", bus.rdata2_o, 32'hDEADBEEF);

        // 2. Writes to x0 never show up.
        bus.raddr1_i = 5'd0;
        bus.raddr2_i = 5'd0;
        drive_mem(5'd0, 1'b1, 32'h1234);
        #1;
        check("t2_n", bus.rdata1_o, 32'h0);
        tick();
        drive_mem(5'd0, 1'b0, 32'h0);
        #1;
        check("t2_n1", bus.rdata2_o, 32'h0);
        tick();
        check("t2_n2", bus.rdata1_o, 32'h0);
        check_outputs("t2");

        // 3. MEM forwarding beats the WB latch.
        bus.raddr1_i = 5'd7;
        bus.raddr2_i = 5'd7;
        drive_idle();
        bus.rd_addr_i = 5'd7; bus.wreg_i = 1'b1; bus.wdata_i = 32'h11;
        tick();
        bus.wreg_i = 1'b0;
        bus.mem_back_rd_addr_i = 5'd7; bus.mem_back_wreg_i = 1'b1; bus.mem_back_wdata_i = 32'h22;
        #1;
        check("t3_mem_wins", bus.rdata1_o, 32'h22);
        check_outputs("t3a");
        tick();
        bus.mem_back_wreg_i = 1'b0;
        #1;
        check("t3_fallback", bus.rdata1_o, 32'h11);
        check_outputs("t3b");

        // 4. Flush squashes the capture, also when combined with stall.
        drive_idle();
        drive_mem(5'd9, 1'b1, 32'h77);
        tick();
        drive_idle();
        tick();
        bus.raddr1_i = 5'd9;
        bus.rd_addr_i = 5'd9; bus.wreg_i = 1'b1; bus.wdata_i = 32'hAA;
        bus.flush_i = 1'b1;
        tick();
        check("t4_flush_wreg", 32'(bus.wb_wreg_o), 32'h0);
        bus.flush_i = 1'b0; bus.wreg_i = 1'b0;
        tick();
        check("t4_x9_old", bus.rdata1_o, 32'h77);
        bus.wreg_i = 1'b1; bus.csr_wreg_i = 1'b1;
        tick();
        check("t4_pre", 32'(bus.wb_wreg_o), 32'h1);
        bus.stall_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        check("t4_sf_wreg", 32'(bus.wb_wreg_o), 32'h0);
        check("t4_sf_csr", 32'(bus.csr_wreg_o), 32'h0);
        check_outputs("t4");

        // 5. Stall holds the latch while MEM inputs change; repeated write is harmless.
        drive_idle();
        bus.raddr1_i = 5'd3;
        bus.rd_addr_i = 5'd3; bus.wreg_i = 1'b1; bus.wdata_i = 32'h55;
        tick();
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.rd_addr_i = ADDR_W'($urandom_range(1, 31));
            bus.wdata_i = $urandom;
            tick();
            check("t5_hold_rd", 32'(bus.wb_rd_addr_o), 32'h3);
            check("t5_hold_data", bus.wb_wdata_o, 32'h55);
            check_outputs("t5");
        end
        drive_idle();
        tick();
        tick();
        check("t5_x3", bus.rdata1_o, 32'h55);

        // 6. CSR write appears one cycle later; async reset clears it and the GPRs.
        bus.csr_waddr_i = 12'h300; bus.csr_wreg_i = 1'b1; bus.csr_wdata_i = 32'h8;
        #1;
        check("t6_before", 32'(bus.csr_wreg_o), 32'h0);
        tick();
        check("t6_addr", 32'(bus.csr_waddr_o), 32'h300);
        check("t6_we", 32'(bus.csr_wreg_o), 32'h1);
        check("t6_data", bus.csr_wdata_o, 32'h8);
        bus.raddr1_i = 5'd5;
        bus.raddr2_i = 5'd3;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_csr", 32'(bus.csr_wreg_o), 32'h0);
        check("t6_rst_x5", bus.rdata1_o, 32'h0);
        check("t6_rst_x3", bus.rdata2_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        check_outputs("t6_after");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            drive_rand();
            #1;
            check_outputs("rand");
            tick();
        end
        drive_idle();
        #1;
        check_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
